// File: rtl/aes_ctr_pkg.sv
// Shared widths, state encoding and counter helper for the AES-CTR stream sequencer.
package aes_ctr_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KEY_W   = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_FETCH = 3'd2,
        ST_CORE  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Counter block advances across the full block width and wraps modulo 2^128.
    function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] ctr);
        return ctr + BLOCK_W'(1);
    endfunction

endpackage

// File: rtl/aes_ctr_sequencer.sv
// Runs a multi-block AES-CTR stream through one shared AES core and key-expansion unit,
// one block in flight at a time, with valid/ready plaintext input and ciphertext output.
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [BLOCK_W-1:0] cfg_ctr,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic               abort,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLOCK_W-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLOCK_W-1:0] m_data,
    output logic               key_start,
    output logic [KEY_W-1:0]   key_out,
    input  logic               key_done,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_block,
    input  logic [BLOCK_W-1:0] core_result,
    input  logic               core_done,
    output logic               busy,
    output logic               done
);

    state_t               state;
    state_t               state_nxt;
    logic [BLOCK_W-1:0]   ctr;
    logic [BLOCK_W-1:0]   ctr_nxt;
    logic [CNT_W-1:0]     remaining;
    logic [CNT_W-1:0]     remaining_nxt;
    logic [BLOCK_W-1:0]   plain;
    logic [BLOCK_W-1:0]   plain_nxt;
    logic [BLOCK_W-1:0]   m_data_nxt;
    logic                 m_valid_nxt;
    logic [KEY_W-1:0]     key_out_nxt;
    logic [BLOCK_W-1:0]   core_block_nxt;
    logic                 key_start_nxt;
    logic                 core_start_nxt;
    logic                 done_nxt;
    logic                 cfg_ready_nxt;
    logic                 s_ready_nxt;
    logic                 busy_nxt;

    // State and datapath registers; every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ctr        <= '0;
            remaining  <= '0;
            plain      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            key_out    <= '0;
            core_block <= '0;
            key_start  <= 1'b0;
            core_start <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctr        <= ctr_nxt;
            remaining  <= remaining_nxt;
            plain      <= plain_nxt;
            m_data     <= m_data_nxt;
            m_valid    <= m_valid_nxt;
            key_out    <= key_out_nxt;
            core_block <= core_block_nxt;
            key_start  <= key_start_nxt;
            core_start <= core_start_nxt;
            done       <= done_nxt;
            cfg_ready  <= cfg_ready_nxt;
            s_ready    <= s_ready_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and next-register logic; abort overrides every transition.
    always_comb begin
        state_nxt      = state;
        ctr_nxt        = ctr;
        remaining_nxt  = remaining;
        plain_nxt      = plain;
        m_data_nxt     = m_data;
        m_valid_nxt    = m_valid;
        key_out_nxt    = key_out;
        core_block_nxt = core_block;
        key_start_nxt  = 1'b0;
        done_nxt       = 1'b0;

        if (abort) begin
            state_nxt      = ST_IDLE;
            ctr_nxt        = '0;
            remaining_nxt  = '0;
            plain_nxt      = '0;
            m_data_nxt     = '0;
            m_valid_nxt    = 1'b0;
            key_out_nxt    = '0;
            core_block_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        key_out_nxt   = cfg_key;
                        ctr_nxt       = cfg_ctr;
                        remaining_nxt = cfg_len;
                        if (cfg_len == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt     = ST_KEY;
                            key_start_nxt = 1'b1;
                        end
                    end
                end
                ST_KEY: begin
                    if (key_done) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        plain_nxt      = s_data;
                        core_block_nxt = ctr;
                        state_nxt      = ST_CORE;
                    end
                end
                ST_CORE: begin
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        m_data_nxt    = core_result ^ plain;
                        m_valid_nxt   = 1'b1;
                        ctr_nxt       = ctr_inc(ctr);
                        remaining_nxt = remaining - CNT_W'(1);
                        state_nxt     = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_nxt = 1'b0;
                        if (remaining == '0) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // Status strobes are decoded from the state being entered so they line up with it.
        core_start_nxt = (state_nxt == ST_CORE);
        cfg_ready_nxt  = (state_nxt == ST_IDLE);
        s_ready_nxt    = (state_nxt == ST_FETCH);
        busy_nxt       = (state_nxt != ST_IDLE);
    end

endmodule
